// File: rtl/bitwise_pipe.sv
// bitwise_pipe: two-stage valid/ready pipeline that applies one of eight
// bitwise operations to two WIDTH-bit operands. Results can be chained
// through an internal accumulator, and Hack-style zr/ng flags are
// registered alongside the result.
module bitwise_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_en,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic [WIDTH-1:0] acc
);

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ANDN = 3'd6,
        OP_NOTA = 3'd7
    } op_e;

    // Stage 1 holding register
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_e              s1_op;
    logic             s1_acc_en;

    // Handshake and datapath wiring
    logic             s2_advance;
    logic             s2_load;
    logic             in_fire;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] result;

    // Stage 2 can take new data whenever it is empty or being drained;
    // stage 1 frees up under the same condition, so a full pipe moves
    // all three steps (drain, shift, accept) in one cycle.
    assign s2_advance = !out_valid || out_ready;
    assign s2_load    = s2_advance && s1_valid;
    assign in_ready   = !s1_valid || s2_advance;
    assign in_fire    = in_valid && in_ready;

    // An accumulate transaction reads the live accumulator at the moment it
    // loads stage 2, which is what lets back-to-back chains run bubble-free.
    assign op_a = s1_acc_en ? acc : s1_a;

    // Bitwise function unit driven by the stage 1 contents
    always_comb begin
        result = '0;
        case (s1_op)
            OP_AND:  result = op_a & s1_b;
            OP_OR:   result = op_a | s1_b;
            OP_XOR:  result = op_a ^ s1_b;
            OP_NAND: result = ~(op_a & s1_b);
            OP_NOR:  result = ~(op_a | s1_b);
            OP_XNOR: result = ~(op_a ^ s1_b);
            OP_ANDN: result = op_a & ~s1_b;
            OP_NOTA: result = ~op_a;
            default: result = '0;
        endcase
    end

    // Stage 1: capture the offered transaction whenever the stage has room
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_op     <= OP_AND;
            s1_acc_en <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_fire) begin
                s1_a      <= a;
                s1_b      <= b;
                s1_op     <= op_e'(op);
                s1_acc_en <= acc_en;
            end
        end
    end

    // Stage 2: register result and flags; everything holds while stalled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out       <= '0;
            zr        <= 1'b0;
            ng        <= 1'b0;
        end else if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out <= result;
                zr  <= (result == '0);
                ng  <= result[WIDTH-1];
            end
        end
    end

    // Accumulator: a clear beats a same-edge accumulate write-back
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (s2_load && s1_acc_en) begin
            acc <= result;
        end
    end

endmodule

// File: tb/tb_bitwise_pipe.sv
// tb_bitwise_pipe: directed vector table, hand-written corner sequences and
// a randomized run scored against a truth-table reference model.
module tb_bitwise_pipe;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic         acc_en;
    logic         acc_clr;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         zr;
    logic         ng;
    logic [W-1:0] acc;

    int checks   = 0;
    int failures = 0;

    // Scoreboard state for the randomized run
    logic [W-1:0] expQ[$];
    logic [W-1:0] modelAcc;
    logic         monOn = 1'b0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expOut;
        logic         expZr;
        logic         expNg;
    } vec_t;

    vec_t vecs[10];

    bitwise_pipe #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zr        (zr),
        .ng        (ng),
        .acc       (acc)
    );

    // Free-running clock
    always #5 clock = ~clock;

    // Reference: each op is a 2-input truth table applied bit by bit,
    // indexed by {a_bit, b_bit}
    function automatic logic [W-1:0] refOp(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [3:0]   tt;
        logic [W-1:0] r;
        case (o)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b1110;
            3'd2:    tt = 4'b0110;
            3'd3:    tt = 4'b0111;
            3'd4:    tt = 4'b0001;
            3'd5:    tt = 4'b1001;
            3'd6:    tt = 4'b0100;
            default: tt = 4'b0011;
        endcase
        r = '0;
        for (int i = 0; i < W; i++) r[i] = tt[{x[i], y[i]}];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkFlag(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after a rising edge; idle cycles carry
    // random junk on the data inputs since it must be ignored
    task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [W-1:0] ia,
                                 input logic [W-1:0] ib, input logic ae, input logic clr, input logic ordy);
        @(posedge clock);
        #1;
        in_valid = v;
        if (v) begin
            op     = o;
            a      = ia;
            b      = ib;
            acc_en = ae;
        end else begin
            op     = 3'($urandom_range(0, 7));
            a      = W'($urandom());
            b      = W'($urandom());
            acc_en = 1'($urandom_range(0, 1));
        end
        acc_clr   = clr;
        out_ready = ordy;
    endtask

    // Step to the next falling edge and check the visible output state
    task automatic expectState(input string tag, input logic ov, input logic [W-1:0] o, input logic [W-1:0] ac);
        @(negedge clock);
        checkFlag({tag, " out_valid"}, out_valid, ov);
        if (ov) begin
            checkOutput({tag, " out"}, out, o);
            checkFlag({tag, " zr"}, zr, (o == '0));
            checkFlag({tag, " ng"}, ng, o[W-1]);
        end
        checkOutput({tag, " acc"}, acc, ac);
    endtask

    // Single transaction on an idle pipe: nothing after the accept edge,
    // result visible after the following edge
    task automatic runVector(input string name, input logic [2:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                             input logic [W-1:0] eo, input logic ez, input logic en);
        applyStimulus(1'b1, o, ia, ib, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        checkFlag({name, " early out_valid"}, out_valid, 1'b0);
        @(negedge clock);
        checkFlag({name, " out_valid"}, out_valid, 1'b1);
        checkOutput({name, " out"}, out, eo);
        checkFlag({name, " zr"}, zr, ez);
        checkFlag({name, " ng"}, ng, en);
    endtask

    // Output monitor for the randomized run: whenever a result is shown it
    // must match the oldest outstanding expectation; it retires on handshake
    always @(negedge clock) begin
        if (monOn && !reset && out_valid) begin
            if (expQ.size() == 0) begin
                checkFlag("rand unexpected out_valid", out_valid, 1'b0);
            end else begin
                checkOutput("rand out", out, expQ[0]);
                checkFlag("rand zr", zr, (expQ[0] == '0));
                checkFlag("rand ng", ng, expQ[0][W-1]);
                if (out_ready) void'(expQ.pop_front());
            end
        end
    end

    // Hard stop if the run ever stalls
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [2:0]   bpOp[4];
    logic [W-1:0] bpA[4];
    logic [W-1:0] bpB[4];
    logic [W-1:0] bpR[4];

    initial begin
        vecs[0] = '{3'd0, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b1};
        vecs[1] = '{3'd1, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0, 1'b1};
        vecs[2] = '{3'd2, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0};
        vecs[3] = '{3'd3, 16'hF0F0, 16'hFF00, 16'h0FFF, 1'b0, 1'b0};
        vecs[4] = '{3'd4, 16'hF0F0, 16'hFF00, 16'h000F, 1'b0, 1'b0};
        vecs[5] = '{3'd5, 16'hF0F0, 16'hFF00, 16'hF00F, 1'b0, 1'b1};
        vecs[6] = '{3'd6, 16'hF0F0, 16'hFF00, 16'h00F0, 1'b0, 1'b0};
        vecs[7] = '{3'd7, 16'hF0F0, 16'hFF00, 16'h0F0F, 1'b0, 1'b0};
        vecs[8] = '{3'd0, 16'h00FF, 16'hFF00, 16'h0000, 1'b1, 1'b0};
        vecs[9] = '{3'd1, 16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        op        = 3'd0;
        acc_en    = 1'b0;
        acc_clr   = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;

        // Reset state
        #2;
        checkFlag("reset out_valid", out_valid, 1'b0);
        checkOutput("reset out", out, '0);
        checkFlag("reset zr", zr, 1'b0);
        checkFlag("reset ng", ng, 1'b0);
        checkOutput("reset acc", acc, '0);
        #10;
        reset = 1'b0;
        @(negedge clock);
        checkFlag("post-reset in_ready", in_ready, 1'b1);

        // Vector table: basic ops and flags
        for (int i = 0; i < 10; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                      vecs[i].expOut, vecs[i].expZr, vecs[i].expNg);
        end

        // Accumulate chain; operand A is junk since the accumulator replaces it
        applyStimulus(1'b0, 3'd0, '0, '0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 3'd1, 16'hA5A5, 16'h0001, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 3'd1, 16'h5A5A, 16'h0002, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 3'd1, 16'hFFFF, 16'h0004, 1'b1, 1'b0, 1'b1);
        expectState("chain1", 1'b1, 16'h0001, 16'h0001);
        applyStimulus(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b1);
        expectState("chain2", 1'b1, 16'h0003, 16'h0003);
        expectState("chain3", 1'b1, 16'h0007, 16'h0007);
        applyStimulus(1'b1, 3'd2, 16'h1234, 16'h0007, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b1);
        expectState("chainxor idle", 1'b0, '0, 16'h0007);
        expectState("chainxor", 1'b1, 16'h0000, 16'h0000);

        // Clear collision: accumulate load and acc_clr on the same edge
        applyStimulus(1'b0, 3'd0, '0, '0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 3'd1, 16'h0000, 16'h00FF, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b1);
        expectState("preload idle", 1'b0, '0, 16'h0000);
        expectState("preload", 1'b1, 16'h00FF, 16'h00FF);
        applyStimulus(1'b1, 3'd1, 16'h0000, 16'hFF00, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'd0, '0, '0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b1);
        expectState("collision", 1'b1, 16'hFFFF, 16'h0000);

        // Backpressure: four transactions against a stalled consumer
        for (int k = 0; k < 4; k++) begin
            bpOp[k] = 3'(k + 2);
            bpA[k]  = W'($urandom());
            bpB[k]  = W'($urandom());
            bpR[k]  = refOp(bpOp[k], bpA[k], bpB[k]);
        end
        applyStimulus(1'b1, bpOp[0], bpA[0], bpB[0], 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, bpOp[1], bpA[1], bpB[1], 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, bpOp[2], bpA[2], bpB[2], 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            expectState($sformatf("bp hold%0d", k), 1'b1, bpR[0], 16'h0000);
            checkFlag($sformatf("bp hold%0d in_ready", k), in_ready, 1'b0);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        @(negedge clock);
        checkFlag("bp release in_ready", in_ready, 1'b1);
        applyStimulus(1'b1, bpOp[3], bpA[3], bpB[3], 1'b0, 1'b0, 1'b1);
        expectState("bp out1", 1'b1, bpR[1], 16'h0000);
        applyStimulus(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b1);
        expectState("bp out2", 1'b1, bpR[2], 16'h0000);
        expectState("bp out3", 1'b1, bpR[3], 16'h0000);
        expectState("bp drained", 1'b0, '0, 16'h0000);

        // Asynchronous reset with both stages occupied
        applyStimulus(1'b1, 3'd7, 16'h1111, 16'h2222, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd0, 16'h1234, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b0);
        expectState("pre-reset", 1'b1, 16'hFFFF, 16'hFFFF);
        checkFlag("pre-reset in_ready", in_ready, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkFlag("midreset out_valid", out_valid, 1'b0);
        checkOutput("midreset out", out, '0);
        checkFlag("midreset zr", zr, 1'b0);
        checkFlag("midreset ng", ng, 1'b0);
        checkOutput("midreset acc", acc, '0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkFlag("release in_ready", in_ready, 1'b1);
        checkFlag("release out_valid", out_valid, 1'b0);
        runVector("after reset", 3'd1, 16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b1);

        // Randomized run against the reference model
        applyStimulus(1'b0, 3'd0, '0, '0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b1);
        modelAcc = '0;
        @(negedge clock);
        monOn = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic         rv;
            logic [2:0]   ro;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rae;
            logic [W-1:0] r;
            rv  = ($urandom_range(0, 9) < 7);
            ro  = 3'($urandom_range(0, 7));
            ra  = W'($urandom());
            rb  = W'($urandom());
            rae = ($urandom_range(0, 2) == 0);
            applyStimulus(rv, ro, ra, rb, rae, 1'b0, ($urandom_range(0, 9) < 6));
            @(negedge clock);
            if (in_valid && in_ready) begin
                r = refOp(ro, rae ? modelAcc : ra, rb);
                if (rae) modelAcc = r;
                expQ.push_back(r);
            end
        end
        applyStimulus(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int t = 0; t < 20; t++) begin
            @(negedge clock);
            #1;
            if (expQ.size() == 0) break;
        end
        checkInt("rand outstanding results", expQ.size(), 0);
        monOn = 1'b0;
        @(negedge clock);
        checkFlag("rand final out_valid", out_valid, 1'b0);
        checkOutput("rand final acc", acc, modelAcc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitwise_pipe.md
# bitwise_pipe

Parametrised, pipelined successor to the fixed 16-bit bitwise gate arrays.
- Performs one of eight bitwise operations on two WIDTH-bit operands per transaction.
- Optionally chains results through an internal accumulator.
- Moves data through a 2-stage valid/ready pipeline with full backpressure.
- Sits between the register file and the write-back path as the logic half of the datapath; it also produces Hack-style zr/ng flags.

## Interface
- WIDTH, 16, operand/result width in bits (≥2)
- clock  in  1  rising-edge clock, single domain
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  transaction offered on a/b/op/acc_en
- in_ready  out  1  stage 1 can accept this cycle
- op  in  3  operation select (see Operation)
- acc_en  in  1  use accumulator as operand A and write result back to it
- acc_clr  in  1  clear accumulator (independent of handshake)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out  out  WIDTH  registered result
- zr  out  1  out == 0, registered with out
- ng  out  1  out[WIDTH-1], registered with out
- acc  out  WIDTH  current accumulator value

## Operation
- op encoding:
  - 0 AND
  - 1 OR
  - 2 XOR
  - 3 NAND
  - 4 NOR
  - 5 XNOR
  - 6 ANDN (A & ~B)
  - 7 NOT A (B ignored)
- All operations are purely bitwise. There is no carry and no width growth. Result width = WIDTH.
- Stage 1 (S1) captures a, b, op, acc_en on the input handshake (in_valid & in_ready).
- Stage 2 (S2) computes the result from the S1 contents and registers out/zr/ng. When the S1 acc_en is set, operand A is the accumulator value at the moment of S2 load, not the S1 a.
- Accumulator write:
  - On an S2 load with acc_en=1, acc <= result at the same edge.
  - Back-to-back accumulate transactions therefore chain with no hazard or bubble.
- acc_clr:
  - Sets acc to 0 at the next edge.
  - If an accumulate write occurs at the same edge, the clear wins: acc=0, and out still shows the computed result.
  - A transaction loading S2 in a cycle where acc_clr=1 uses the pre-clear acc value.
- Flow control:
  - S2 advances when !out_valid | out_ready.
  - S1 advances into S2 under the same condition.
  - in_ready = !s1_valid | s2_advance.
  - Throughput is 1 transaction/cycle with out_ready held high.
- out/zr/ng hold stable while out_valid=1 and out_ready=0.
- Inputs are ignored when in_valid=0. No transaction is dropped or duplicated.

## Timing
- Reset values (asynchronous, immediate):
  - s1_valid=0
  - out_valid=0
  - out=0
  - zr=0
  - ng=0
  - acc=0
  - in_ready=1 after release
- Latency: input accepted at edge N; out_valid=1 with result after edge N+1 (2 edges from accept to visible result on an idle pipe).
- Full pipe with out_ready=0:
  - S1 and S2 both hold.
  - in_ready=0 combinationally in the same cycle.
- When out_ready rises on a full pipe, all three happen in one cycle:
  - S2 is consumed.
  - S1 moves to S2.
  - A new input is accepted.
- Reset asserted mid-operation discards both stages and the accumulator. No out_valid is produced for in-flight transactions.
- in_ready depends combinationally on out_ready. out_valid, out, zr, ng and acc are registered only.

## Test plan
- Basic ops (WIDTH=16, out_ready=1): a=16'hF0F0, b=16'hFF00, sweep op 0..7 -> outputs, each 2 edges after its accept, in order:
  - F000
  - FFF0
  - 0FF0
  - 0FFF
  - 000F
  - F00F
  - 00F0
  - 0F0F
- Flags: AND of 16'h00FF and 16'hFF00 -> out=0000, zr=1, ng=0. OR of 16'h8000 and 0 -> out=8000, zr=0, ng=1.
- Accumulate chain:
  - acc_clr, then acc_en=1 with op=OR, b=0001, 0002, 0004 back-to-back.
  - Required: outputs 0001, 0003, 0007, acc=0007.
  - Follow with op=XOR, b=0007 -> out=0000, zr=1, acc=0000.
- Backpressure:
  - Stream 4 transactions with out_ready=0.
  - Required: pipe holds 2, in_ready=0 while full, out stable.
  - Then raise out_ready: all 4 results emerge in order with no loss or duplication.
- Clear collision: acc=00FF, accumulate OR b=FF00 loads S2 in the same cycle acc_clr=1 -> out=FFFF, acc=0000 next cycle.
- Async reset mid-stream: assert reset with both stages valid -> out_valid=0, out=0, acc=0 immediately. After release, in_ready=1 and the next transaction completes in 2 edges.
